cla_multicycle_adder: RTL and testbench

//   Sequencing controller that adds two WIDTH-bit operands over WIDTH/CHUNK cycles
//   by reusing one CHUNK-bit carry-look-ahead slice (g/p generate + group G/P/carry).

---
 rtl/cla_multicycle_adder_pkg.sv | 21 ++
 rtl/cla_multicycle_adder_chunk.sv | 57 +++++
 rtl/cla_multicycle_adder.sv | 136 +++++++++++++
 tb/tb_cla_multicycle_adder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_multicycle_adder_pkg.sv
// Shared types and helpers for the multicycle carry-look-ahead adder.
// Holds the FSM state encoding, index width helper and the g/p combine cell.
package cla_multicycle_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

  // Combine a high (g,p) pair with the adjacent lower pair: returns {g, p}.
  function automatic logic [1:0] gp_combine(input logic g_hi, input logic p_hi,
                                            input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

endpackage

// File: rtl/cla_multicycle_adder_chunk.sv
// Combinational CHUNK-bit carry-look-ahead slice: per-bit g/p, a log-depth
// prefix tree of g/p combine cells, the resulting carries and group G/P.
module cla_chunk
  import cla_multicycle_adder_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb,
  output logic             grp_g,
  output logic             grp_p
);

  localparam int LVL = $clog2(CHUNK);

  logic [LVL:0][CHUNK-1:0] gt;
  logic [LVL:0][CHUNK-1:0] pt;
  logic [CHUNK:0]          c;

  // Prefix tree: after level LVL, gt/pt[i] describe the span [i:0].
  always_comb begin
    int d;
    int lo;
    gt    = '0;
    pt    = '0;
    c     = '0;
    gt[0] = a & b;
    pt[0] = a ^ b;
    for (int l = 1; l <= LVL; l++) begin
      d = 1 << (l - 1);
      for (int i = 0; i < CHUNK; i++) begin
        lo = (i >= d) ? (i - d) : i;
        if (i >= d) begin
          {gt[l][i], pt[l][i]} = gp_combine(gt[l-1][i], pt[l-1][i], gt[l-1][lo], pt[l-1][lo]);
        end else begin
          gt[l][i] = gt[l-1][i];
          pt[l][i] = pt[l-1][i];
        end
      end
    end
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = gt[LVL][i] | (pt[LVL][i] & ci);
    end
  end

  assign s     = pt[0] ^ c[CHUNK-1:0];
  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];
  assign grp_g = gt[LVL][CHUNK-1];
  assign grp_p = pt[LVL][CHUNK-1];

endmodule

// File: rtl/cla_multicycle_adder.sv
// Adds two WIDTH-bit operands over WIDTH/CHUNK cycles through one shared CLA
// slice, rippling the chunk carry through a register; valid/ready on both sides.
module cla_multicycle_adder
  import cla_multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_s;
  logic             slice_co;
  logic             slice_c_msb;
  logic             slice_g;
  logic             slice_p;
  logic             last;

  assign slice_a = a_op[int'(idx) * CHUNK +: CHUNK];
  assign slice_b = b_op[int'(idx) * CHUNK +: CHUNK];
  assign last    = (idx == LAST_IDX);

  cla_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (slice_a),
    .b     (slice_b),
    .ci    (carry),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_c_msb),
    .grp_g (slice_g),
    .grp_p (slice_p)
  );

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and handshake flags; in_ready stays low while reset is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ST_IDLE);
      out_valid <= (state_nxt == ST_DONE);
    end
  end

  // Operand capture, per-chunk accumulation and final carry/overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_op  <= {WIDTH{1'b0}};
      b_op  <= {WIDTH{1'b0}};
      idx   <= {IDX_W{1'b0}};
      carry <= 1'b0;
      sum   <= {WIDTH{1'b0}};
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_op  <= a;
            b_op  <= b;
            carry <= cin;
            idx   <= {IDX_W{1'b0}};
          end
        end
        ST_RUN: begin
          sum[int'(idx) * CHUNK +: CHUNK] <= slice_s;
          // Group look-ahead gives the same value as the slice carry-out.
          carry <= slice_g | (slice_p & carry);
          if (last) begin
            cout <= slice_co;
            ovf  <= slice_c_msb ^ slice_co;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_multicycle_adder.sv
// Directed and randomised checks of cla_multicycle_adder against a 33-bit
// arithmetic model, for CHUNK=8 (main instance) plus CHUNK=4 and CHUNK=32.
module tb_cla_multicycle_adder;

  localparam int NCHUNK = 4;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_x = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int since_rst = 0;
  int xdone = 0;
  res_t exp_q[$];
  int   acc_q[$];
  bit   seen_valid = 1'b0;

  always #5 clk = ~clk;

  cla_multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] t;
    res_t r;
    t   = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    r.s = t[31:0];
    r.c = t[32];
    r.o = (x[31] == y[31]) && (t[31] != x[31]);
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) since_rst = 0;
    else     since_rst++;
  end

  // Scoreboard for the main instance, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      seen_valid = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
    end else begin
      if (since_rst >= 1) check("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          if (!seen_valid) begin
            check("latency", 64'(cyc - acc_q[0]), 64'(NCHUNK));
            seen_valid = 1'b1;
          end
          check("sum", 64'(sum), 64'(exp_q[0].s));
          check("cout", 64'(cout), 64'(exp_q[0].c));
          check("ovf", 64'(ovf), 64'(exp_q[0].o));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            seen_valid = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                       input bit rnd, output logic [31:0] rs, output logic rc, output logic ro);
    int n;
    rs = 32'd0;
    rc = 1'b0;
    ro = 1'b0;
    a = ta;
    b = tb_v;
    cin = tc;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    n = 0;
    while (!(out_valid && out_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (!(out_valid && out_ready)) begin
      check("result_timeout", 64'd0, 64'd1);
      return;
    end
    rs = sum;
    rc = cout;
    ro = ovf;
    @(posedge clk); #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                     input logic tc, input logic [31:0] es, input logic ec, input logic eo);
    logic [31:0] rs;
    logic rc;
    logic ro;
    do_op(ta, tb_v, tc, 1'b0, rs, rc, ro);
    check({nm, "_sum"}, 64'(rs), 64'(es));
    check({nm, "_cout"}, 64'(rc), 64'(ec));
    check({nm, "_ovf"}, 64'(ro), 64'(eo));
  endtask

  // Extra configurations: CHUNK=4 (8 chunks) and CHUNK=32 (single chunk).
  for (genvar gi = 0; gi < 2; gi++) begin : gx
    localparam int CH = (gi == 0) ? 4 : 32;
    localparam int NC = 32 / CH;
    logic        x_in_valid;
    logic        x_in_ready;
    logic [31:0] x_a;
    logic [31:0] x_b;
    logic        x_cin;
    logic        x_out_valid;
    logic [31:0] x_sum;
    logic        x_cout;
    logic        x_ovf;

    cla_multicycle_adder #(.WIDTH(32), .CHUNK(CH)) u_dut (
      .clk(clk), .rst(rst_x), .in_valid(x_in_valid), .in_ready(x_in_ready),
      .a(x_a), .b(x_b), .cin(x_cin), .out_valid(x_out_valid), .out_ready(1'b1),
      .sum(x_sum), .cout(x_cout), .ovf(x_ovf)
    );

    initial begin : x_drv
      res_t e;
      int n;
      x_in_valid = 1'b0;
      x_a = 32'd0;
      x_b = 32'd0;
      x_cin = 1'b0;
      wait (rst_x == 1'b0);
      @(posedge clk); #1;
      for (int i = 0; i < 40; i++) begin
        if (i == 0) begin
          x_a = 32'hFFFF_FFFF; x_b = 32'h0000_0001; x_cin = 1'b0;
        end else if (i == 1) begin
          x_a = 32'h7FFF_FFFF; x_b = 32'h0000_0001; x_cin = 1'b0;
        end else begin
          x_a = $urandom; x_b = $urandom; x_cin = 1'($urandom_range(0, 1));
        end
        e = model(x_a, x_b, x_cin);
        n = 0;
        while (!x_in_ready && n < 100) begin @(posedge clk); #1; n++; end
        x_in_valid = 1'b1;
        @(posedge clk); #1;
        x_in_valid = 1'b0;
        n = 0;
        while (!x_out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check($sformatf("x%0d_latency", CH), 64'(n), 64'(NC));
        check($sformatf("x%0d_sum", CH), 64'(x_sum), 64'(e.s));
        check($sformatf("x%0d_cout", CH), 64'(x_cout), 64'(e.c));
        check($sformatf("x%0d_ovf", CH), 64'(x_ovf), 64'(e.o));
        @(posedge clk); #1;
      end
      xdone++;
    end
  end

  initial begin : main
    logic [31:0] rs;
    logic rc;
    logic ro;
    int n;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 32'd0;
    b = 32'd0;
    cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst_x = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    lit("ffff_plus_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    lit("pos_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    lit("neg_ovf",     32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    lit("cin_only",    32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    lit("chunk_cross", 32'h0000_FF00, 32'h0000_0100, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    lit("all_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    lit("min_plus_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Backpressure: result held in DONE while out_ready is low.
    out_ready = 1'b0;
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i % 2);
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_sum", 64'(sum), 64'h2345_6789);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 64'(out_valid), 64'd0);

    // Reset two cycles into a run aborts it immediately.
    a = 32'hFFFF_0000; b = 32'h0000_FFFF; cin = 1'b1; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_abort", 64'(in_ready), 64'd1);
    lit("after_abort", 32'h89AB_CDEF, 32'h7654_3211, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Random operands with random consumer backpressure; checked by the scoreboard.
    for (int i = 0; i < 300; i++) begin
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, rs, rc, ro);
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    n = 0;
    while (xdone < 2 && n < 5000) begin @(posedge clk); n++; end
    check("extra_configs_done", 64'(xdone), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
